// File: rtl/video_format_stabilizer.sv
// video_format_stabilizer
//
// Purpose:
//   Sits behind the video format detector. Re-times the filtered vsync and
//   the 8-bit format code into the 50 MHz domain. Samples the code once per
//   frame, a fixed delay after each vsync falling edge. Debounces it over
//   STABLE_FRAMES identical samples. Forces the code to 0x00 when vsync
//   disappears. Publishes the committed format together with a
//   change-request / acknowledge handshake for the board controller.
//
// Parameters:
//   STABLE_FRAMES  - identical consecutive samples needed to commit (1..15)
//   SAMPLE_DELAY   - clk cycles after the vsync falling edge before sampling
//   TIMEOUT_CYCLES - clk cycles without a vsync edge before a forced 0x00
//
// Ports:
//   clk_50mhz_in     in   system clock, 50 MHz
//   rst_n_in         in   asynchronous active-low reset
//   vsync_in         in   filtered vsync, asynchronous to the clock
//   format_in [7:0]  in   detector format code (quasi-static between edges)
//   ack_in           in   one-cycle acknowledge from the controller
//   format_out [7:0] out  committed stable format code
//   locked_out       out  high while format_out is not 0x00
//   change_req_out   out  high from a commit until acknowledged
//   frame_tick_out   out  one-cycle pulse per detected vsync falling edge
//   change_count_out out  commits since last acknowledge, saturating
//                         (present only with the optional feature)
//
// Optional feature macro: VIDEO_FORMAT_STABILIZER_CHANGE_COUNT_EN
//   When this macro is defined, the module adds change_count_out.
`timescale 1ns/1ps
`default_nettype none

module video_format_stabilizer #(
  parameter int STABLE_FRAMES  = 4,
  parameter int SAMPLE_DELAY   = 1000,
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic       clk_50mhz_in,
  input  logic       rst_n_in,
  input  logic       vsync_in,
  input  logic [7:0] format_in,
  input  logic       ack_in,
  output logic [7:0] format_out,
  output logic       locked_out,
  output logic       change_req_out,
  output logic       frame_tick_out
`ifdef VIDEO_FORMAT_STABILIZER_CHANGE_COUNT_EN
  ,
  output logic [7:0] change_count_out
`endif
);

  localparam logic [15:0] DELAY_LAST   = 16'(SAMPLE_DELAY - 1);
  localparam logic [21:0] TIMEOUT_LAST = 22'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  STABLE_COUNT = 4'(STABLE_FRAMES);

  typedef enum logic [1:0] {
    WAIT_EDGE = 2'd0,
    DELAY     = 2'd1,
    COMPARE   = 2'd2
  } state_t;

  logic [1:0]  rst_pipe;
  logic        rst_n;
  logic        vsync_meta;
  logic        vsync_sync;
  logic        vsync_prev;
  logic        vsync_fall;
  logic [21:0] timeout_count;
  logic        timeout_hit;
  logic [15:0] delay_count;
  logic        delay_done;
  logic        timeout_sample;
  logic [7:0]  sample;
  logic [7:0]  candidate;
  logic [3:0]  match_count;
  logic [3:0]  next_match;
  logic        commit;
  state_t      state;
  state_t      next_state;

  // Reset asserts asynchronously but releases on a clock edge. Every other
  // flop is therefore reset together and leaves reset in the same cycle.
  always_ff @(posedge clk_50mhz_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  assign rst_n = rst_pipe[1];

  // Two-flop synchronizer plus one history flop for vsync edge detection.
  always_ff @(posedge clk_50mhz_in or negedge rst_n) begin
    if (!rst_n) begin
      vsync_meta <= 1'b0;
      vsync_sync <= 1'b0;
      vsync_prev <= 1'b0;
    end else begin
      vsync_meta <= vsync_in;
      vsync_sync <= vsync_meta;
      vsync_prev <= vsync_sync;
    end
  end

  assign vsync_fall     = vsync_prev & ~vsync_sync;
  assign frame_tick_out = vsync_fall;

  // The timeout counter free-runs between edges and wraps on expiry. While
  // vsync is absent, this wrap produces a forced sample every TIMEOUT_CYCLES.
  always_ff @(posedge clk_50mhz_in or negedge rst_n) begin
    if (!rst_n) begin
      timeout_count <= '0;
    end else if (vsync_fall || timeout_count == TIMEOUT_LAST) begin
      timeout_count <= '0;
    end else begin
      timeout_count <= timeout_count + 22'd1;
    end
  end

  assign timeout_hit = ~vsync_fall && (timeout_count == TIMEOUT_LAST);

  // Sample triggers: the end of the post-edge delay, or a timeout in idle.
  // An edge in the final delay cycle wins, so the delay restarts.
  assign delay_done     = (state == DELAY) && ~vsync_fall && (delay_count == DELAY_LAST);
  assign timeout_sample = (state == WAIT_EDGE) && timeout_hit;

  always_ff @(posedge clk_50mhz_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_EDGE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      WAIT_EDGE: begin
        if (vsync_fall) begin
          next_state = DELAY;
        end else if (timeout_hit) begin
          next_state = COMPARE;
        end
      end
      DELAY: begin
        if (delay_done) begin
          next_state = COMPARE;
        end
      end
      COMPARE: begin
        next_state = WAIT_EDGE;
      end
      default: begin
        next_state = WAIT_EDGE;
      end
    endcase
  end

  // The delay counter clears on every edge. Entry to DELAY and an edge seen
  // during DELAY both restart the count.
  always_ff @(posedge clk_50mhz_in or negedge rst_n) begin
    if (!rst_n) begin
      delay_count <= '0;
    end else if (vsync_fall) begin
      delay_count <= '0;
    end else if (state == DELAY) begin
      delay_count <= delay_count + 16'd1;
    end
  end

  // format_in only moves at vsync edges. A single capture register is
  // therefore enough to bring it into this clock domain.
  always_ff @(posedge clk_50mhz_in or negedge rst_n) begin
    if (!rst_n) begin
      sample <= 8'h00;
    end else if (delay_done) begin
      sample <= format_in;
    end else if (timeout_sample) begin
      sample <= 8'h00;
    end
  end

  // The candidate always becomes the new sample. The match count either
  // saturates at STABLE_FRAMES or restarts at one.
  always_comb begin
    next_match = 4'd1;
    if (sample == candidate) begin
      next_match = (match_count >= STABLE_COUNT) ? STABLE_COUNT : match_count + 4'd1;
    end
  end

  assign commit = (state == COMPARE) && (next_match == STABLE_COUNT) && (sample != format_out);

  always_ff @(posedge clk_50mhz_in or negedge rst_n) begin
    if (!rst_n) begin
      candidate   <= 8'h00;
      match_count <= 4'd0;
    end else if (state == COMPARE) begin
      candidate   <= sample;
      match_count <= next_match;
    end
  end

  // The committed format and the lock flag load together, so they never
  // disagree.
  always_ff @(posedge clk_50mhz_in or negedge rst_n) begin
    if (!rst_n) begin
      format_out <= 8'h00;
      locked_out <= 1'b0;
    end else if (commit) begin
      format_out <= sample;
      locked_out <= (sample != 8'h00);
    end
  end

  // A commit takes priority over a same-cycle acknowledge. The controller
  // must then see the request again for the newer format.
  always_ff @(posedge clk_50mhz_in or negedge rst_n) begin
    if (!rst_n) begin
      change_req_out <= 1'b0;
    end else if (commit) begin
      change_req_out <= 1'b1;
    end else if (ack_in) begin
      change_req_out <= 1'b0;
    end
  end

`ifdef VIDEO_FORMAT_STABILIZER_CHANGE_COUNT_EN
  // Counts the commits that the controller has not yet acknowledged.
  always_ff @(posedge clk_50mhz_in or negedge rst_n) begin
    if (!rst_n) begin
      change_count_out <= 8'h00;
    end else if (commit) begin
      if (change_count_out != 8'hFF) begin
        change_count_out <= change_count_out + 8'd1;
      end
    end else if (ack_in && change_req_out) begin
      change_count_out <= 8'h00;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_video_format_stabilizer.sv
// tb_video_format_stabilizer
//
// Purpose:
//   Drives vsync frames and format codes into video_format_stabilizer. The
//   frames use both directed sequences and random code runs. The bench
//   compares the outputs against a frame-history reference model: a format
//   commits once the last STABLE_FRAMES samples agree and differ from the
//   committed value.
//
// Optional feature macro: VIDEO_FORMAT_STABILIZER_CHANGE_COUNT_EN
//   When this macro is defined, the bench also checks change_count_out.
`timescale 1ns/1ps

module tb_video_format_stabilizer;

  localparam int STABLE_FRAMES  = 4;
  localparam int SAMPLE_DELAY   = 10;
  localparam int TIMEOUT_CYCLES = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vsync;
  logic [7:0] format_code;
  logic       ack;
  logic [7:0] format_out;
  logic       locked_out;
  logic       change_req_out;
  logic       frame_tick_out;
`ifdef VIDEO_FORMAT_STABILIZER_CHANGE_COUNT_EN
  logic [7:0] change_count_out;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] hist[$];
  logic [7:0] m_format;
  logic       m_req;
  int         m_count;

  always #10 clk = ~clk;

  video_format_stabilizer #(
    .STABLE_FRAMES (STABLE_FRAMES),
    .SAMPLE_DELAY  (SAMPLE_DELAY),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk_50mhz_in  (clk),
    .rst_n_in      (rst_n),
    .vsync_in      (vsync),
    .format_in     (format_code),
    .ack_in        (ack),
    .format_out    (format_out),
    .locked_out    (locked_out),
    .change_req_out(change_req_out),
    .frame_tick_out(frame_tick_out)
`ifdef VIDEO_FORMAT_STABILIZER_CHANGE_COUNT_EN
    ,
    .change_count_out(change_count_out)
`endif
  );

  function automatic void model_reset();
    hist.delete();
    m_format = 8'h00;
    m_req    = 1'b0;
    m_count  = 0;
  endfunction

  // A commit happens when the most recent STABLE_FRAMES samples are all
  // equal and that value differs from the committed one.
  function automatic void model_sample(input logic [7:0] s);
    bit stable;
    hist.push_back(s);
    stable = (hist.size() >= STABLE_FRAMES);
    if (stable) begin
      for (int i = 1; i <= STABLE_FRAMES; i++) begin
        if (hist[hist.size() - i] != s) stable = 1'b0;
      end
    end
    if (stable && s != m_format) begin
      m_format = s;
      m_req    = 1'b1;
      if (m_count < 255) m_count++;
    end
  endfunction

  function automatic void model_ack();
    if (m_req) begin
      m_req   = 1'b0;
      m_count = 0;
    end
  endfunction

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_value({tag, ".format"}, 32'(format_out), 32'(m_format));
    check_value({tag, ".locked"}, 32'(locked_out), 32'(m_format != 8'h00));
    check_value({tag, ".req"}, 32'(change_req_out), 32'(m_req));
    check_value({tag, ".tick"}, 32'(frame_tick_out), 32'd0);
`ifdef VIDEO_FORMAT_STABILIZER_CHANGE_COUNT_EN
    check_value({tag, ".count"}, 32'(change_count_out), 32'(m_count));
`endif
  endtask

  // One frame: vsync high long enough to settle, then a falling edge that
  // carries the new code, then low_cycles clocks before the model advances.
  task automatic run_frame(input logic [7:0] code, input int low_cycles);
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    vsync       = 1'b0;
    format_code = code;
    repeat (low_cycles) @(negedge clk);
    model_sample(code);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    model_ack();
  endtask

  // Guards against a hang if something stalls the sequence.
  initial begin
    #20_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] debounce_seq [7];
    logic [7:0] code;
    int         run_len;

    debounce_seq = '{8'h02, 8'h02, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02};
    rst_n        = 1'b0;
    vsync        = 1'b0;
    format_code  = 8'h00;
    ack          = 1'b0;
    model_reset();

    // Reset values
    repeat (3) @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // First lock: nothing may appear before the fourth frame
    for (int i = 0; i < 3; i++) begin
      run_frame(8'h01, 20);
      check_outputs("lock_pre");
    end
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    vsync       = 1'b0;
    format_code = 8'h01;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check_value("lock_tick", 32'(frame_tick_out), 32'(k == 2));
      check_value("lock_latency.format", 32'(format_out), (k >= 14) ? 32'h01 : 32'h00);
      check_value("lock_latency.req", 32'(change_req_out), 32'(k >= 14));
    end
    model_sample(8'h01);
    check_outputs("lock_done");

    // Debounce: the interleaved 0x01 restarts the count
    for (int i = 0; i < 7; i++) begin
      run_frame(debounce_seq[i], 20);
      check_outputs("debounce");
    end

    // Acknowledge clears the request; a spare acknowledge does nothing
    pulse_ack();
    check_outputs("ack_clear");
    pulse_ack();
    check_outputs("ack_idle");

    // Random runs of codes with random frame lengths and acknowledges
    for (int f = 0; f < 40;) begin
      code    = 8'($urandom_range(0, 4));
      run_len = $urandom_range(1, 6);
      for (int r = 0; r < run_len && f < 40; r++) begin
        run_frame(code, $urandom_range(16, 50));
        f++;
        check_outputs("random_frame");
        if ($urandom_range(0, 3) == 0) begin
          pulse_ack();
          check_outputs("random_ack");
        end
      end
    end

    // A second commit while pending, then an ack that lands on a commit
    for (int i = 0; i < 4; i++) run_frame(8'h01, 20);
    for (int i = 0; i < 4; i++) run_frame(8'h02, 20);
    check_outputs("pending_commit");
    for (int i = 0; i < 3; i++) run_frame(8'h04, 20);
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    vsync       = 1'b0;
    format_code = 8'h04;
    repeat (13) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    model_sample(8'h04);
    repeat (6) @(negedge clk);
    check_outputs("ack_vs_commit");

    // Reset asserted in the middle of the post-edge delay
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    vsync       = 1'b0;
    format_code = 8'h01;
    repeat (6) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("reset_mid_delay");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_frame(8'h04, 20);
    check_outputs("post_reset_one");
    for (int i = 0; i < 3; i++) run_frame(8'h04, 20);
    check_outputs("post_reset_four");

    // Loss of vsync: four timeouts force 0x00
    pulse_ack();
    for (int i = 0; i < 3; i++) run_frame(8'h03, 20);
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    vsync       = 1'b0;
    format_code = 8'h03;
    repeat (20) @(negedge clk);
    model_sample(8'h03);
    check_outputs("loss_locked");
    pulse_ack();
    check_outputs("loss_acked");
    repeat (378) @(negedge clk);
    check_outputs("loss_before");
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) model_sample(8'h00);
    check_outputs("loss_forced");

`ifdef VIDEO_FORMAT_STABILIZER_CHANGE_COUNT_EN
    // Commit counter: three commits, then saturation
    pulse_ack();
    check_outputs("count_cleared");
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 4; i++) run_frame((c % 2 == 0) ? 8'h01 : 8'h02, 16);
    end
    check_outputs("count_three");
    check_value("count_three_abs", 32'(change_count_out), 32'd3);
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 4; i++) run_frame((c % 2 == 0) ? 8'h02 : 8'h01, 16);
    end
    check_outputs("count_saturated");
    check_value("count_saturated_abs", 32'(change_count_out), 32'hFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_format_stabilizer.md
Name: video_format_stabilizer

Overview:
- Sits directly downstream of the video format detector; consumes its 8-bit format code (0x00 none, 0x01 576i50, 0x02 480i60, 0x03 576p50, 0x04 480p60) and the filtered vsync.
- Re-times both into the 50 MHz domain and debounces the code over N consecutive frames.
- Detects loss of vsync and forces the format to 0x00.
- Publishes a stable format and a change-request/acknowledge handshake for the board controller.

Parameters:
- STABLE_FRAMES, 4, consecutive identical frame samples required before commit (range 1..15).
- SAMPLE_DELAY, 1000, clk cycles after the synchronized vsync falling edge at which format_in is sampled (range 1..65535).
- TIMEOUT_CYCLES, 2500000, clk cycles without a vsync falling edge before a forced 0x00 sample (50 ms at 50 MHz).

Ports:
- clk_50mhz_in  input  1  system clock, 50 MHz
- rst_n_in  input  1  asynchronous active-low reset
- vsync_in  input  1  filtered vsync, asynchronous to clk
- format_in  input  8  format code from the detector; changes only on a vsync falling edge
- ack_in  input  1  one-cycle acknowledge from the controller, synchronous to clk
- format_out  output  8  committed stable format code
- locked_out  output  1  high while format_out != 0x00
- change_req_out  output  1  high from commit until acknowledged
- frame_tick_out  output  1  one-cycle pulse per detected vsync falling edge

Behaviour:
- Reset (async assert, sync release internally): format_out=0x00, locked_out=0, change_req_out=0, frame_tick_out=0, candidate=0x00, match count=0, timeout counter=0, FSM=WAIT_EDGE.
- vsync_in passes through a 2-FF synchronizer plus one history FF. A falling edge is sync_d=0 with prev=1. frame_tick_out pulses in the same cycle the edge is detected (3 clk max after the pin).
- FSM:
  - WAIT_EDGE: on edge, clear the delay counter -> DELAY. On timeout -> COMPARE with sample=0x00.
  - DELAY: count up. When the count equals SAMPLE_DELAY-1, register format_in as the sample -> COMPARE. format_in is treated as quasi-static; a single-register capture is legal because it changes only at vsync edges.
  - DELAY restart: an edge seen during DELAY restarts the delay count and stays in DELAY.
  - COMPARE (one cycle):
    - If sample==candidate: count = min(count+1, STABLE_FRAMES).
    - Else: candidate=sample, count=1.
    - If the new count==STABLE_FRAMES and candidate!=format_out: commit. format_out=candidate and change_req_out=1 in the next cycle.
    - Return to WAIT_EDGE.
- Timeout counter:
  - Cleared on every edge; otherwise increments.
  - When it reaches TIMEOUT_CYCLES-1 it generates the timeout event and reloads to 0, so repeated 0x00 samples occur every TIMEOUT_CYCLES while vsync is absent.
  - A timeout during DELAY is ignored, because the edge that started DELAY cleared the counter.
- Commit latency from the STABLE_FRAMES-th sample: 1 clk after COMPARE.
- locked_out is registered and updates in the same cycle as format_out.
- Handshake:
  - change_req_out stays high until ack_in=1, then clears next cycle.
  - A commit in the same cycle as ack_in wins: change_req_out stays 1.
  - ack_in while change_req_out=0 has no effect.
  - A second commit while pending keeps change_req_out=1 and format_out shows the latest value.
- Same-value samples after commit never re-assert change_req_out.
- Counter widths: delay counter 16 bits, timeout counter 22 bits, match count 4 bits, saturating.
- Reset mid-DELAY or mid-handshake returns all state to reset values immediately.

Optional Feature:
- Macro: VIDEO_FORMAT_STABILIZER_CHANGE_COUNT_EN.
- Defined: adds output port change_count_out (8 bits).
  - Reset 0x00.
  - Increments by 1 on each commit, saturating at 0xFF.
  - Cleared to 0x00 on an ack_in that coincides with a commit-free cycle while change_req_out=1.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then 4 vsync edges with format_in=0x01 (STABLE_FRAMES=4, SAMPLE_DELAY=10) -> format_out=0x01, locked_out=1, change_req_out=1 exactly 1 clk after the 4th COMPARE; none of these before the 4th frame.
- Debounce: stable 0x01, then the sequence 0x02,0x02,0x01,0x02,0x02,0x02,0x02 -> format_out changes to 0x02 only after the final 0x02; the intermediate 0x01 resets the count, and format_out never glitches.
- Loss of vsync (TIMEOUT_CYCLES=100) with format_out=0x03 -> after 4 x 100 cycles without an edge: format_out=0x00, locked_out=0, change_req_out=1.
- Handshake: change_req_out=1, pulse ack_in -> 0 next cycle. ack_in coincident with a new commit -> change_req_out remains 1 and format_out shows the new value.
- Asynchronous rst_n_in low during DELAY -> all outputs 0 in the same cycle. After release, one vsync edge alone does not commit; 4 edges with 0x04 are required.
- With VIDEO_FORMAT_STABILIZER_CHANGE_COUNT_EN: 3 commits -> change_count_out=3; 300 commits -> 0xFF.
